// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, scoring/lives constants
// and the saturating score adder.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        INVULN    = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int LIVES_INIT    = 3;
    localparam int INVULN_FRAMES = 30;
    localparam int SCORE_ENEMY   = 10;
    localparam int SCORE_HD      = 25;
    localparam int SCORE_MAX     = 999;

    localparam int SCORE_W = 10;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 5;

    // One extra bit of headroom covers SCORE_MAX plus both increments.
    function automatic logic [SCORE_W-1:0] score_add(
        input logic [SCORE_W-1:0] score,
        input logic               enemy,
        input logic               hd
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, score}
            + (enemy ? (SCORE_W+1)'(SCORE_ENEMY) : '0)
            + (hd    ? (SCORE_W+1)'(SCORE_HD)    : '0);
        return (sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/frame_once_pulse.sv
// Per-frame first-sighting detector: each bit pulses for one cycle, one
// cycle after its level is first seen high within the current frame.
module frame_once_pulse #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] seen_live;
    logic [WIDTH-1:0] first;

    // A level coinciding with startOfFrame belongs to the new frame, so the
    // frame boundary bypasses the stored flags instead of waiting a cycle.
    always_comb begin
        seen_live = startOfFrame ? '0 : seen;
        first     = level & ~seen_live;
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seen  <= '0;
            pulse <= '0;
        end else begin
            seen  <= seen_live | level;
            pulse <= first;
        end
    end

endmodule

// File: rtl/collision_event_manager.sv
// Turns per-pixel collision levels into once-per-frame event pulses and
// runs the score / lives / invulnerability game FSM.
module collision_event_manager
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               newGame,
    input  logic [2:0]         ShotBoxCollision,
    input  logic [2:0]         ShotEnemyCollision,
    input  logic               ShotHeadsDownCollision,
    input  logic               TowerEnemyHUCollision,
    input  logic               towerPlayerCollision,
    output logic [2:0]         shotKill,
    output logic               enemyHit,
    output logic               headsDownHit,
    output logic               playerBlocked,
    output logic               lifeLost,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         gameState
);

    game_state_t        state, state_next;
    logic [LIVES_W-1:0] lives_next;
    logic [SCORE_W-1:0] score_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    logic [2:0] shot_pulse;
    logic [3:0] evt_level, evt_pulse;
    logic       active;

    frame_once_pulse #(.WIDTH(3)) u_shot (
        .clk          (clk),
        .reset        (reset),
        .clear        (newGame),
        .startOfFrame (startOfFrame),
        .level        (ShotBoxCollision | ShotEnemyCollision),
        .pulse        (shot_pulse)
    );

    assign evt_level = {towerPlayerCollision, TowerEnemyHUCollision,
                        ShotHeadsDownCollision, |ShotEnemyCollision};

    frame_once_pulse #(.WIDTH(4)) u_event (
        .clk          (clk),
        .reset        (reset),
        .clear        (newGame),
        .startOfFrame (startOfFrame),
        .level        (evt_level),
        .pulse        (evt_pulse)
    );

    // Pulses are masked at the output so nothing escapes once the game ends.
    assign active        = (state != GAME_OVER);
    assign shotKill      = active ? shot_pulse : 3'b000;
    assign enemyHit      = active & evt_pulse[0];
    assign headsDownHit  = active & evt_pulse[1];
    assign playerBlocked = active & evt_pulse[3];
    assign lifeLost      = (state == PLAY) & evt_pulse[2] & (lives != '0);
    assign gameState     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PLAY;
            lives <= LIVES_W'(LIVES_INIT);
            score <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            lives <= lives_next;
            score <= score_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        lives_next = lives;
        score_next = score;
        cnt_next   = cnt;
        if (newGame) begin
            state_next = PLAY;
            lives_next = LIVES_W'(LIVES_INIT);
            score_next = '0;
            cnt_next   = '0;
        end else begin
            score_next = score_add(score, enemyHit, headsDownHit);
            case (state)
                PLAY: begin
                    if (lifeLost) begin
                        lives_next = lives - 1'b1;
                        if (lives == LIVES_W'(1)) begin
                            state_next = GAME_OVER;
                        end else begin
                            state_next = INVULN;
                            cnt_next   = CNT_W'(INVULN_FRAMES);
                        end
                    end
                end
                INVULN: begin
                    if (startOfFrame) begin
                        if (cnt <= CNT_W'(1)) begin
                            state_next = PLAY;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt - 1'b1;
                        end
                    end
                end
                GAME_OVER: ;
                default: state_next = PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_event_manager.sv
// Self-checking bench for collision_event_manager: a vector table fed through
// a scoreboard queue plus hand-written multi-frame sequences.
module tb_collision_event_manager;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, newGame;
    logic [2:0] ShotBoxCollision, ShotEnemyCollision;
    logic       ShotHeadsDownCollision, TowerEnemyHUCollision, towerPlayerCollision;
    logic [2:0] shotKill;
    logic       enemyHit, headsDownHit, playerBlocked, lifeLost;
    logic [9:0] score;
    logic [1:0] lives, gameState;

    int checks = 0;
    int errors = 0;
    int ll_count = 0;
    int kill_cycles, ehit_cycles;

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_INV  = 2'd1;
    localparam logic [1:0] ST_GO   = 2'd2;

    always #5 clk = ~clk;

    collision_event_manager dut (
        .clk                    (clk),
        .reset                  (reset),
        .startOfFrame           (startOfFrame),
        .newGame                (newGame),
        .ShotBoxCollision       (ShotBoxCollision),
        .ShotEnemyCollision     (ShotEnemyCollision),
        .ShotHeadsDownCollision (ShotHeadsDownCollision),
        .TowerEnemyHUCollision  (TowerEnemyHUCollision),
        .towerPlayerCollision   (towerPlayerCollision),
        .shotKill               (shotKill),
        .enemyHit               (enemyHit),
        .headsDownHit           (headsDownHit),
        .playerBlocked          (playerBlocked),
        .lifeLost               (lifeLost),
        .score                  (score),
        .lives                  (lives),
        .gameState              (gameState)
    );

    typedef struct packed {
        logic       sof, ng;
        logic [2:0] box, enm;
        logic       hd, hu, pl;
    } stim_t;

    typedef struct packed {
        logic [2:0] kill;
        logic       ehit, hdhit, pblk, llost;
        logic [9:0] score;
        logic [1:0] lives, state;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t r;
    } vec_t;

    resp_t exp_q[$];
    vec_t  vecs[16];

    always @(negedge clk) if (lifeLost) ll_count++;

    function automatic stim_t S(input logic sof, input logic ng, input logic [2:0] box,
                                input logic [2:0] enm, input logic hd, input logic hu,
                                input logic pl);
        stim_t s;
        s.sof = sof; s.ng = ng; s.box = box; s.enm = enm; s.hd = hd; s.hu = hu; s.pl = pl;
        return s;
    endfunction

    function automatic resp_t R(input logic [2:0] kill, input logic e, input logic h,
                                input logic p, input logic l, input logic [9:0] sc,
                                input logic [1:0] lv, input logic [1:0] st);
        resp_t r;
        r.kill = kill; r.ehit = e; r.hdhit = h; r.pblk = p; r.llost = l;
        r.score = sc; r.lives = lv; r.state = st;
        return r;
    endfunction

    function automatic resp_t observe();
        return {shotKill, enemyHit, headsDownHit, playerBlocked, lifeLost, score, lives, gameState};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then land 1 time unit past the edge.
    task automatic apply(input stim_t s);
        startOfFrame           = s.sof;
        newGame                = s.ng;
        ShotBoxCollision       = s.box;
        ShotEnemyCollision     = s.enm;
        ShotHeadsDownCollision = s.hd;
        TowerEnemyHUCollision  = s.hu;
        towerPlayerCollision   = s.pl;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input stim_t s, input resp_t r);
        exp_q.push_back(r);
        apply(s);
        check(name, observe(), exp_q.pop_front());
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        apply(S(0, 0, 0, 0, 0, 0, 0));
        apply(S(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
    endtask

    task automatic idle();
        apply(S(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic sof();
        apply(S(1, 0, 0, 0, 0, 0, 0));
    endtask

    // Frame start, tower hit, then one cycle for the FSM to act on the pulse.
    task automatic hit_tower();
        sof();
        apply(S(0, 0, 0, 0, 0, 1, 0));
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        reset_dut();
        check("reset_state", observe(), R(0, 0, 0, 0, 0, 0, 3, ST_PLAY));

        // Table: shots, enemy, heads-down, player, frame wrap, newGame in PLAY.
        vecs[0]  = '{S(1, 0, 3'b000, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0,  0, 3, ST_PLAY)};
        vecs[1]  = '{S(0, 0, 3'b000, 3'b010, 0, 0, 0), R(3'b010, 1, 0, 0, 0,  0, 3, ST_PLAY)};
        vecs[2]  = '{S(0, 0, 3'b000, 3'b010, 0, 0, 0), R(3'b000, 0, 0, 0, 0, 10, 3, ST_PLAY)};
        vecs[3]  = '{S(0, 0, 3'b001, 3'b010, 0, 0, 0), R(3'b001, 0, 0, 0, 0, 10, 3, ST_PLAY)};
        vecs[4]  = '{S(0, 0, 3'b001, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0, 10, 3, ST_PLAY)};
        vecs[5]  = '{S(0, 0, 3'b000, 3'b000, 0, 0, 1), R(3'b000, 0, 0, 1, 0, 10, 3, ST_PLAY)};
        vecs[6]  = '{S(0, 0, 3'b000, 3'b000, 0, 0, 1), R(3'b000, 0, 0, 0, 0, 10, 3, ST_PLAY)};
        vecs[7]  = '{S(1, 0, 3'b000, 3'b010, 0, 0, 1), R(3'b010, 1, 0, 1, 0, 10, 3, ST_PLAY)};
        vecs[8]  = '{S(0, 0, 3'b000, 3'b000, 1, 0, 0), R(3'b000, 0, 1, 0, 0, 20, 3, ST_PLAY)};
        vecs[9]  = '{S(0, 0, 3'b000, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0, 45, 3, ST_PLAY)};
        vecs[10] = '{S(1, 0, 3'b000, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0, 45, 3, ST_PLAY)};
        vecs[11] = '{S(0, 0, 3'b000, 3'b100, 1, 0, 0), R(3'b100, 1, 1, 0, 0, 45, 3, ST_PLAY)};
        vecs[12] = '{S(0, 0, 3'b000, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0, 80, 3, ST_PLAY)};
        vecs[13] = '{S(0, 1, 3'b000, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0,  0, 3, ST_PLAY)};
        vecs[14] = '{S(0, 0, 3'b000, 3'b100, 0, 0, 0), R(3'b100, 1, 0, 0, 0,  0, 3, ST_PLAY)};
        vecs[15] = '{S(0, 0, 3'b000, 3'b000, 0, 0, 0), R(3'b000, 0, 0, 0, 0, 10, 3, ST_PLAY)};
        for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i].s, vecs[i].r);

        // Enemy collision held for 40 cycles within one frame.
        reset_dut();
        sof();
        kill_cycles = 0;
        ehit_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            apply(S(0, 0, 3'b000, 3'b010, 0, 0, 0));
            if (shotKill == 3'b010) kill_cycles++;
            if (enemyHit) ehit_cycles++;
        end
        check("held_kill_cycles", kill_cycles, 1);
        check("held_ehit_cycles", ehit_cycles, 1);
        check("held_score", score, 10);

        // Saturation: climb to 980 then add both increments together.
        reset_dut();
        for (int i = 0; i < 28; i++) begin
            apply(S(1, 0, 3'b000, 3'b001, 1, 0, 0));
            idle();
        end
        check("score_980", score, 980);
        apply(S(1, 0, 3'b000, 3'b001, 1, 0, 0));
        check("both_pulses", {shotKill, enemyHit, headsDownHit}, {3'b001, 1'b1, 1'b1});
        idle();
        check("score_saturated", score, 999);

        // Consecutive-frame tower hits and invulnerability length.
        reset_dut();
        ll_count = 0;
        sof();
        apply(S(0, 0, 0, 0, 0, 1, 0));
        check("first_lifelost", {lifeLost, lives}, {1'b1, 2'd3});
        idle();
        check("enter_invuln", {lifeLost, lives, gameState}, {1'b0, 2'd2, ST_INV});
        sof();
        check("invuln_sof1", gameState, ST_INV);
        apply(S(0, 0, 0, 0, 0, 1, 0));
        check("invuln_ignores_hu", lifeLost, 1'b0);
        idle();
        check("invuln_lives", lives, 2);
        for (int k = 2; k <= 30; k++) begin
            sof();
            check($sformatf("invuln_sof%0d", k), gameState, (k == 30) ? ST_PLAY : ST_INV);
        end

        // Lose the remaining lives, frames spaced past the invulnerable window.
        apply(S(0, 0, 0, 3'b001, 0, 0, 0));
        idle();
        check("score_before_end", score, 10);
        hit_tower();
        check("second_hit", {lives, gameState}, {2'd1, ST_INV});
        for (int k = 0; k < 31; k++) sof();
        check("back_to_play", gameState, ST_PLAY);
        hit_tower();
        check("third_hit", {lives, gameState}, {2'd0, ST_GO});
        check("lifelost_count", ll_count, 3);
        for (int k = 0; k < 4; k++) begin
            apply(S(k == 0, 0, 3'b111, 3'b111, 1, 1, 1));
            check($sformatf("gameover_quiet%0d", k),
                  {shotKill, enemyHit, headsDownHit, playerBlocked, lifeLost}, 7'b0);
        end
        idle();
        check("gameover_frozen", {score, lives, gameState}, {10'd10, 2'd0, ST_GO});
        check("lifelost_after_end", ll_count, 3);

        // newGame alone from GAME_OVER.
        apply(S(0, 1, 0, 0, 0, 0, 0));
        check("newgame_restart", observe(), R(0, 0, 0, 0, 0, 0, 3, ST_PLAY));

        // Back to GAME_OVER, then reset racing newGame and every collision.
        hit_tower();
        for (int k = 0; k < 31; k++) sof();
        hit_tower();
        for (int k = 0; k < 31; k++) sof();
        hit_tower();
        check("second_gameover", {lives, gameState}, {2'd0, ST_GO});
        reset = 1'b1;
        apply(S(1, 1, 3'b111, 3'b111, 1, 1, 1));
        reset = 1'b0;
        check("reset_beats_all", observe(), R(0, 0, 0, 0, 0, 0, 3, ST_PLAY));
        idle();
        check("post_reset_quiet", observe(), R(0, 0, 0, 0, 0, 0, 3, ST_PLAY));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_event_manager.md
COLLISION_EVENT_MANAGER -- requirements
Module: collision_event_manager

Interface
REQ-001 clk  in  1  system clock.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 startOfFrame  in  1  single-cycle pulse at start of each frame.
REQ-004 newGame  in  1  single-cycle restart request.
REQ-005 ShotBoxCollision  in  3  per-pixel level; bit i = shot i overlaps a tower.
REQ-006 ShotEnemyCollision  in  3  per-pixel level; bit i = shot i overlaps an enemy.
REQ-007 ShotHeadsDownCollision  in  1  per-pixel level; some shot overlaps a heads-down enemy.
REQ-008 TowerEnemyHUCollision  in  1  per-pixel level; heads-up enemy overlaps a tower.
REQ-009 towerPlayerCollision  in  1  per-pixel level; player overlaps a tower.
REQ-010 shotKill  out  3  one-cycle pulse per shot; retire shot i.
REQ-011 enemyHit  out  1  one-cycle pulse; enemy struck this frame.
REQ-012 headsDownHit  out  1  one-cycle pulse; heads-down enemy struck this frame.
REQ-013 playerBlocked  out  1  one-cycle pulse; player touched a tower this frame.
REQ-014 lifeLost  out  1  one-cycle pulse; a life was deducted.
REQ-015 score  out  10  binary score, 0..999.
REQ-016 lives  out  2  remaining lives.
REQ-017 gameState  out  2  PLAY / INVULN / GAME_OVER encoding.
REQ-018 Parameters: LIVES_INIT=3, INVULN_FRAMES=30, SCORE_ENEMY=10, SCORE_HD=25, SCORE_MAX=999.

Function
REQ-019 Each collision source (shot bits 0..2, enemy, HD, HU-tower, player-tower) SHALL use a per-frame "seen" flag; the first cycle the source is high with the flag clear sets the flag.
REQ-020 The corresponding output pulse SHALL assert exactly one cycle, on the cycle after that first sighting (registered, latency 1).
REQ-021 All seen flags SHALL clear on startOfFrame; a collision in the same cycle as startOfFrame SHALL count as the first sighting of the new frame.
REQ-022 shotKill[i] SHALL pulse when bit i of ShotBoxCollision or ShotEnemyCollision is first seen in the frame; at most one pulse per shot per frame.
REQ-023 enemyHit SHALL pulse on the first ShotEnemyCollision!=0 in a frame; score SHALL increase by SCORE_ENEMY on that pulse.
REQ-024 headsDownHit SHALL pulse on the first ShotHeadsDownCollision in a frame; score SHALL increase by SCORE_HD.
REQ-025 When enemyHit and headsDownHit pulse together, both increments SHALL apply in the same cycle; the sum SHALL saturate at SCORE_MAX.
REQ-026 playerBlocked SHALL pulse once per frame on towerPlayerCollision in every state except GAME_OVER.
REQ-027 FSM states: PLAY, INVULN, GAME_OVER.
REQ-028 PLAY: first TowerEnemyHUCollision in a frame -> lifeLost pulse, lives decrement; if lives becomes 0 -> GAME_OVER, else -> INVULN with frame counter loaded to INVULN_FRAMES.
REQ-029 INVULN: TowerEnemyHUCollision ignored; the counter decrements on each startOfFrame; at 0 -> PLAY on the same cycle as that startOfFrame. Scoring and shotKill remain active.
REQ-030 GAME_OVER: all pulse outputs held 0; score and lives frozen; newGame -> PLAY, lives=LIVES_INIT, score=0, flags cleared.
REQ-031 newGame in PLAY or INVULN SHALL have the same effect as in GAME_OVER.
REQ-032 lives SHALL never underflow below 0.

Reset
REQ-033 On reset (synchronous, active-high, sampled at clk): state=PLAY, lives=LIVES_INIT, score=0, all seen flags=0, INVULN counter=0, all pulse outputs=0.
REQ-034 Reset SHALL take priority over newGame, startOfFrame and all collision inputs in the same cycle.

Structure
REQ-035 A shared package game_pkg SHALL hold the state enum and the LIVES_INIT, INVULN_FRAMES, SCORE_* constants.
REQ-036 A sub-module frame_once_pulse (WIDTH parameter; level in, startOfFrame, pulse out) SHALL implement REQ-019..021 and SHALL be instantiated once per source group.

Verification
REQ-037 ShotEnemyCollision=3'b010 held for 40 cycles within one frame -> shotKill=3'b010 and enemyHit each high exactly 1 cycle; score 0->10.
REQ-038 ShotEnemyCollision and ShotHeadsDownCollision first seen in the same cycle, score=980 -> score=999 (saturated), both pulses high together.
REQ-039 TowerEnemyHUCollision in 3 separate frames, each more than 30 frames apart -> lives 3->2->1->0, lifeLost 3 times, gameState=GAME_OVER; further collisions produce no pulses.
REQ-040 TowerEnemyHUCollision in two consecutive frames -> one lifeLost only; INVULN exits after exactly 30 startOfFrame pulses.
REQ-041 Collision asserted in the same cycle as startOfFrame after the flag was set in the prior frame -> a new pulse is emitted for the new frame.
REQ-042 reset and newGame asserted together in GAME_OVER -> reset values only; newGame asserted alone in GAME_OVER -> PLAY, lives=3, score=0.
